// File: rtl/soc_system_quad_enc_counter.sv
// Quadrature encoder front end: synchronises and glitch-filters raw A/B/Z
// encoder lines and decodes Gray-code steps into a 32-bit signed position.
//
// Ports:
//   clk, reset_n   - clock, synchronous active-low reset
//   enc_a, enc_b   - raw encoder channels (asynchronous)
//   enc_z          - raw encoder index pulse (asynchronous)
//   clr            - synchronous clear of count and err
//   index_clr_en   - when 1, a filtered rising edge on Z zeroes count
//   count          - signed position (modular, 32-bit)
//   dir            - direction of last accepted step (1 = forward)
//   err            - sticky illegal-transition flag
module soc_system_quad_enc_counter #(
  parameter int unsigned FILTER_LEN  = 4,
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_z,
  input  logic        clr,
  input  logic        index_clr_en,
  output logic [31:0] count,
  output logic        dir,
  output logic        err
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned FCNT_W = 8;
  localparam int unsigned INIT_W = 4;
  localparam int unsigned NCH    = 3;

  localparam logic [FCNT_W-1:0] FLT_LAST  = FCNT_W'(FILTER_LEN - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES);

  // Channel bit positions within the packed channel vectors
  localparam int unsigned CH_A = 2;
  localparam int unsigned CH_B = 1;
  localparam int unsigned CH_Z = 0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [INIT_W-1:0]            init_cnt;
  logic [NCH-1:0]               s1;
  logic [NCH-1:0]               s2;
  logic [NCH-1:0]               filt;
  logic [NCH-1:0][FCNT_W-1:0]   fcnt;
  logic [1:0]                   prev_ab;
  logic                         prev_z;

  logic                         init_load_c;
  logic                         run_c;
  logic [1:0]                   cur_ab_c;
  logic                         step_fwd_c;
  logic                         step_rev_c;
  logic                         step_bad_c;
  logic                         index_rise_c;

  // Two-flop synchronisers for the asynchronous encoder pins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {enc_a, enc_b, enc_z};
      s2 <= s1;
    end
  end

  // Per-channel stability filter; INIT exit seeds the accepted level directly
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt <= '0;
      fcnt <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        if (init_load_c) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else if (s2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FLT_LAST) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCNT_W'(1);
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: INIT lasts until the synchronisers hold real pin levels
  always_comb begin
    state_nxt = state;
    if ((state == ST_INIT) && (init_cnt == INIT_LAST)) begin
      state_nxt = ST_RUN;
    end
  end

  // FSM outputs
  always_comb begin
    init_load_c = 1'b0;
    run_c       = 1'b0;
    if (state == ST_INIT) begin
      init_load_c = (init_cnt == INIT_LAST);
    end else begin
      run_c = 1'b1;
    end
  end

  // INIT wait counter; counts INIT_CYCLES fill cycles, loads on the next one
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      init_cnt <= '0;
    end else if ((state == ST_INIT) && (init_cnt != INIT_LAST)) begin
      init_cnt <= init_cnt + INIT_W'(1);
    end
  end

  // Gray-code step decode of previous vs. current filtered A/B
  always_comb begin
    cur_ab_c   = {filt[CH_A], filt[CH_B]};
    step_fwd_c = 1'b0;
    step_rev_c = 1'b0;
    step_bad_c = 1'b0;
    case ({prev_ab, cur_ab_c})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step_fwd_c = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step_rev_c = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: step_bad_c = 1'b1;
      default: ;
    endcase
    index_rise_c = run_c & index_clr_en & ~prev_z & filt[CH_Z];
  end

  // Previous filtered levels used for edge/step detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_ab <= '0;
      prev_z  <= 1'b0;
    end else if (init_load_c) begin
      prev_ab <= {s2[CH_A], s2[CH_B]};
      prev_z  <= s2[CH_Z];
    end else if (run_c) begin
      prev_ab <= cur_ab_c;
      prev_z  <= filt[CH_Z];
    end
  end

  // Position, direction and sticky error; clr beats index beats step
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
      dir   <= 1'b0;
      err   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      err   <= 1'b0;
    end else if (run_c) begin
      if (index_rise_c) begin
        count <= '0;
      end else if (step_fwd_c) begin
        count <= count + CNT_W'(1);
      end else if (step_rev_c) begin
        count <= count - CNT_W'(1);
      end
      if (step_fwd_c) begin
        dir <= 1'b1;
      end else if (step_rev_c) begin
        dir <= 1'b0;
      end
      if (step_bad_c) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_soc_system_quad_enc_counter.sv
// Self-checking bench for soc_system_quad_enc_counter: stimulus tasks update a
// position model and queue expected output values tagged with the cycle they
// must appear; a monitor compares them on the falling edge.
module tb_soc_system_quad_enc_counter;

  localparam int unsigned FL  = 4;
  localparam int unsigned LAT = FL + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enc_a = 1'b0;
  logic        enc_b = 1'b0;
  logic        enc_z = 1'b0;
  logic        clr = 1'b0;
  logic        index_clr_en = 1'b0;
  logic [31:0] count;
  logic        dir;
  logic        err;

  soc_system_quad_enc_counter #(.FILTER_LEN(FL), .INIT_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .clr(clr), .index_clr_en(index_clr_en), .count(count), .dir(dir), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned cyc;
    int          tag;
    logic [31:0] count;
    logic        dir;
    logic        chk_dir;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  // Behavioural model: position as plain integer arithmetic on Gray indices
  logic [31:0] m_count = '0;
  logic        m_dir = 1'b0;
  logic        m_dir_known = 1'b1;
  logic        m_err = 1'b0;
  logic [1:0]  m_ab = 2'b00;
  int          tag_seq = 0;

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gcode(input int i);
    case (i & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic push(input int unsigned c);
    exp_t e;
    e.cyc = c;
    e.tag = tag_seq;
    e.count = m_count;
    e.dir = m_dir;
    e.chk_dir = m_dir_known;
    e.err = m_err;
    sbq.push_back(e);
    tag_seq++;
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(posedge clk);
  endtask

  // Change A/B at once; check old value one edge before and new value at latency
  task automatic drive_ab(input logic [1:0] ab);
    int unsigned n;
    int d;
    @(posedge clk); #1;
    n = cyc;
    push(n + LAT);
    enc_a = ab[1];
    enc_b = ab[0];
    d = ((gidx(ab) - gidx(m_ab)) + 4) % 4;
    if (d == 1) begin
      m_count = m_count + 32'd1; m_dir = 1'b1; m_dir_known = 1'b1;
    end else if (d == 3) begin
      m_count = m_count - 32'd1; m_dir = 1'b0; m_dir_known = 1'b1;
    end else if (d == 2) begin
      m_err = 1'b1;
    end
    m_ab = ab;
    push(n + LAT + 1);
  endtask

  task automatic fwd(input int hold);
    drive_ab(gcode(gidx(m_ab) + 1));
    wait_cyc(hold - 1);
  endtask

  task automatic rev(input int hold);
    drive_ab(gcode(gidx(m_ab) + 3));
    wait_cyc(hold - 1);
  endtask

  task automatic do_reset(input logic [1:0] ab);
    int unsigned n;
    @(posedge clk); #1;
    n = cyc;
    reset_n = 1'b0;
    enc_a = ab[1];
    enc_b = ab[0];
    enc_z = 1'b0;
    m_count = '0; m_dir = 1'b0; m_dir_known = 1'b1; m_err = 1'b0; m_ab = ab;
    push(n + 1);
    wait_cyc(3); #1;
    reset_n = 1'b1;
    wait_cyc(10); #1;
    push(cyc);
  endtask

  // B excursion of len cycles that the filter must reject
  task automatic short_glitch(input int len);
    @(posedge clk); #1;
    enc_b = ~enc_b;
    wait_cyc(len); #1;
    enc_b = ~enc_b;
    wait_cyc(12); #1;
    push(cyc);
  endtask

  task automatic clr_pulse();
    int unsigned n;
    @(posedge clk); #1;
    n = cyc;
    clr = 1'b1;
    m_count = '0; m_err = 1'b0;
    @(posedge clk); #1;
    clr = 1'b0;
    push(n + 1);
  endtask

  task automatic index_pulse(input logic en);
    int unsigned n;
    index_clr_en = en;
    @(posedge clk); #1;
    n = cyc;
    push(n + LAT);
    enc_z = 1'b1;
    if (en) m_count = '0;
    push(n + LAT + 1);
    wait_cyc(12); #1;
    enc_z = 1'b0;
    wait_cyc(12); #1;
    push(cyc);
    index_clr_en = 1'b0;
  endtask

  // Forward step whose count update lands on the same edge clr is sampled
  task automatic clr_with_step();
    int unsigned n;
    @(posedge clk); #1;
    n = cyc;
    push(n + LAT);
    m_ab = gcode(gidx(m_ab) + 1);
    enc_a = m_ab[1];
    enc_b = m_ab[0];
    m_count = '0; m_err = 1'b0; m_dir_known = 1'b0;
    wait_cyc(int'(LAT)); #1;
    clr = 1'b1;
    push(n + LAT + 1);
    @(posedge clk); #1;
    clr = 1'b0;
    wait_cyc(10); #1;
    push(cyc);
  endtask

  // Monitor: compare queued expectations on the falling edge
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      if (e.cyc != cyc) begin
        n_checks++; n_fail++;
        $display("FAIL late tag=%0d due_cyc=%0d now=%0d", e.tag, e.cyc, cyc);
      end else begin
        n_checks++;
        if (count !== e.count) begin
          n_fail++;
          $display("FAIL count tag=%0d cyc=%0d got=%h exp=%h", e.tag, cyc, count, e.count);
        end
        n_checks++;
        if (err !== e.err) begin
          n_fail++;
          $display("FAIL err tag=%0d cyc=%0d got=%b exp=%b", e.tag, cyc, err, e.err);
        end
        if (e.chk_dir) begin
          n_checks++;
          if (dir !== e.dir) begin
            n_fail++;
            $display("FAIL dir tag=%0d cyc=%0d got=%b exp=%b", e.tag, cyc, dir, e.dir);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] nab;
    int r;

    // Pre-existing 11 level through reset must not count or flag
    do_reset(2'b11);

    // 8 forward then 3 reverse steps
    for (int i = 0; i < 8; i++) fwd(6);
    for (int i = 0; i < 3; i++) rev(6);

    // Settle at 00, then glitch rejection and minimum accepted pulse
    fwd(8);
    short_glitch(3);
    enc_a = ~enc_a;
    wait_cyc(1); #1;
    enc_a = ~enc_a;
    wait_cyc(12); #1;
    push(cyc);
    drive_ab(2'b01);
    wait_cyc(3);
    drive_ab(2'b00);
    wait_cyc(10);

    // Wrap around zero from reset
    do_reset(2'b00);
    rev(8);
    fwd(8);
    fwd(8);

    // Illegal double transition, following legal step, clear
    rev(8);
    drive_ab(2'b11);
    wait_cyc(9);
    fwd(8);
    clr_pulse();

    // Random walk including illegal jumps, at up to the maximum step rate
    for (int i = 0; i < 50; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)      nab = gcode(gidx(m_ab) + 1);
      else if (r < 9) nab = gcode(gidx(m_ab) + 3);
      else            nab = gcode(gidx(m_ab) + 2);
      drive_ab(nab);
      wait_cyc(int'($urandom_range(FL, FL + 5)) - 1);
    end
    wait_cyc(10);
    clr_pulse();

    // Mid-count reset, then count to 37 at the maximum step rate
    for (int i = 0; i < 5; i++) fwd(6);
    wait_cyc(4);
    do_reset(2'b00);
    for (int i = 0; i < 37; i++) fwd(int'(FL));
    wait_cyc(10);

    // Index: disabled keeps 37, enabled zeroes count
    index_pulse(1'b0);
    index_pulse(1'b1);
    for (int i = 0; i < 3; i++) fwd(6);
    clr_with_step();
    rev(8);

    wait_cyc(20);
    if (sbq.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain pending=%0d exp=0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
